// File: rtl/crc_pkg.sv
// crc_pkg: shared widths and FSM encoding for the CRC result output path.
package crc_pkg;
    localparam int CRC_DATA_W = 60;
    localparam int CRC_CNT_W  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/crc_out_serializer_sync_fifo.sv
// sync_fifo: circular-buffer FIFO with combinational head read; caller gates push when full.
module sync_fifo #(
    parameter int DATA_W = 60,
    parameter int DEPTH  = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wp_q, rp_q;
    logic [CW-1:0]     cnt_q;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wp_q <= inc(wp_q);
            if (pop) rp_q <= inc(rp_q);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem_q[rp_q];
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
endmodule

// File: rtl/crc_out_serializer.sv
// crc_out_serializer: buffers CRC result words and shifts them out MSB-first on a
// valid/ready serial link, dropping and counting words that arrive while full.
module crc_out_serializer
    import crc_pkg::*;
#(
    parameter int DATA_W = CRC_DATA_W,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = CRC_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_valid,
    output logic              ser_data,
    output logic              ser_last,
    input  logic              ser_ready,
    output logic              busy,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int IW = $clog2(DATA_W);
    localparam int CW = $clog2(DEPTH + 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, head;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              xfer, last, pop, push, drop, full, empty;
    logic [CW-1:0]     count;

    // A pop frees a slot this cycle, so a push at full still fits.
    assign xfer = state_q == ST_SHIFT && ser_ready;
    assign last = idx_q == '0;
    assign pop  = !empty && (state_q == ST_IDLE || (xfer && last));
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = pop ? ST_SHIFT : (xfer && last) ? ST_IDLE : state_q;
        shreg_d = pop ? head : xfer ? shreg_q << 1 : shreg_q;
        idx_d   = pop ? IW'(DATA_W - 1) : xfer ? idx_q - 1'b1 : idx_q;
        cnt_d   = (drop && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        ovf_d   = ovf_q | drop;
    end

    always_comb begin
        ser_valid = state_q == ST_SHIFT;
        ser_data  = ser_valid & shreg_q[DATA_W-1];
        ser_last  = ser_valid & last;
        busy      = ser_valid || count != '0;
        overflow  = ovf_q;
        drop_cnt  = cnt_q;
    end
endmodule

// File: tb/tb_crc_out_serializer.sv
// tb_crc_out_serializer: directed and random stimulus against a queue-based word model.
module tb_crc_out_serializer;
    localparam int DW = 60;
    localparam int DEPTH = 2;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst, in_valid, ser_valid, ser_data, ser_last, ser_ready, busy, overflow;
    logic [DW-1:0] in_data;
    logic [CW-1:0] drop_cnt;

    int total = 0, bad = 0;
    logic [DW-1:0] fq[$], sent[$];
    logic [DW-1:0] cur = '0, rx = '0;
    int rem = 0, mcnt = 0, beats = 0;
    logic mov = 1'b0, live = 1'b0;

    crc_out_serializer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_last  (ser_last),
        .ser_ready (ser_ready),
        .busy      (busy),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom, $urandom});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs at negedge, advance the word model.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic rs);
        logic xfer, pop, acc;
        in_valid = v; in_data = d; ser_ready = r; rst = rs;
        @(negedge clk);
        if (live) begin
            chk("valid", ser_valid, rem > 0);
            if (rem > 0) begin
                chk("data", ser_data, cur[rem-1]);
                chk("last", ser_last, rem == 1);
            end
            chk("busy", busy, rem > 0 || fq.size() > 0);
            chk("overflow", overflow, mov);
            chk("drop_cnt", drop_cnt, mcnt);
        end
        if (rs) begin
            fq.delete(); sent.delete();
            rem = 0; mcnt = 0; mov = 1'b0; rx = '0; live = 1'b1;
        end else begin
            xfer = rem > 0 && r;
            pop  = fq.size() > 0 && (rem == 0 || (xfer && rem == 1));
            acc  = v && (fq.size() < DEPTH || pop);
            if (xfer) begin
                rx = {rx[DW-2:0], ser_data};
                beats++;
                rem--;
                if (rem == 0) begin
                    chk("word_expected", sent.size() > 0, 1);
                    if (sent.size() > 0) chk("word", rx, sent.pop_front());
                end
            end
            if (pop) begin cur = fq.pop_front(); rem = DW; end
            if (acc) begin fq.push_back(d); sent.push_back(d); end
            else if (v) begin mov = 1'b1; if (mcnt < 255) mcnt++; end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input logic rand_ready);
        for (int i = 0; i < 4000 && (rem > 0 || fq.size() > 0); i++)
            cyc(1'b0, '0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
        chk("drained_busy", busy, 0);
    endtask

    initial begin
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("rst_valid", ser_valid, 0);
        chk("rst_data", ser_data, 0);
        chk("rst_last", ser_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_cnt", drop_cnt, 0);

        // single word, two-cycle latency
        cyc(1'b1, 60'hA5A_5A5A_5A5A_5A5A, 1'b1, 1'b0);
        chk("lat_t1_valid", ser_valid, 0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("lat_t2_valid", ser_valid, 1);
        chk("lat_t2_msb", ser_data, 1);
        drain(1'b0);

        // back-to-back words, no bubble
        beats = 0;
        cyc(1'b1, '0, 1'b1, 1'b0);
        cyc(1'b1, '1, 1'b1, 1'b0);
        drain(1'b0);
        chk("b2b_beats", beats, 120);
        chk("b2b_ovf", overflow, 0);

        // overflow while stalled
        for (int i = 0; i < 5; i++) cyc(1'b1, rnd(), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("ovf_cnt", drop_cnt, 2);
        chk("ovf_flag", overflow, 1);
        beats = 0;
        drain(1'b0);
        chk("ovf_beats", beats, 180);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // random backpressure over one word
        cyc(1'b1, 60'h123_4567_89AB_CDEF, 1'b0, 1'b0);
        drain(1'b1);

        // push at full coinciding with the last-beat pop
        for (int i = 0; i < 3; i++) cyc(1'b1, rnd(), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 200 && rem != 1; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, rnd(), 1'b1, 1'b0);
        chk("fullpop_cnt", drop_cnt, 0);
        chk("fullpop_ovf", overflow, 0);
        beats = 0;
        drain(1'b0);
        chk("fullpop_beats", beats, 180);

        // reset partway through a word
        cyc(1'b1, rnd(), 1'b1, 1'b0);
        for (int i = 0; i < 100 && rem != DW - 29; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("midrst_valid", ser_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", drop_cnt, 0);
        cyc(1'b1, 60'hFED_CBA9_8765_4321, 1'b1, 1'b0);
        drain(1'b0);

        // drop counter saturation
        for (int i = 0; i < 260; i++) cyc(1'b1, rnd(), 1'b0, 1'b0);
        chk("sat_cnt", drop_cnt, 255);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 69) == 0, rnd(), $urandom_range(0, 3) != 0,
                $urandom_range(0, 999) == 0);
        drain(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
